psram_uart_cmd: RTL and testbench



---
 rtl/psram_uart_cmd.sv | 202 ++++++++++++++++++++
 tb/tb_psram_uart_cmd.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_uart_cmd.sv
// psram_uart_cmd: turns UART byte frames into single 16-bit PSRAM transactions.
// A frame is opcode + three address bytes (+ two data bytes for writes). The block
// launches one psram operation, waits for endcommand and replies over the UART
// transmitter with 'K', the read word, 'T' on operation timeout, or '?' for an
// unknown opcode.
module psram_uart_cmd #(
    parameter logic [15:0] BYTE_TIMEOUT = 16'd8400,
    parameter logic [7:0]  OP_TIMEOUT   = 8'd64
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        qpi_on,
    input  logic        endcommand,
    input  logic [15:0] data_out,
    output logic [22:0] address,
    output logic [1:0]  read_write,
    output logic        quad_start,
    output logic [15:0] data_in,
    output logic        busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_WAIT_RDY = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;
    localparam logic [2:0] S_WAIT_END = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] RSP_OK     = 8'h4B;
    localparam logic [7:0] RSP_BAD    = 8'h3F;
    localparam logic [7:0] RSP_TMO    = 8'h54;

    logic [2:0]  state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [15:0] byte_timer;
    logic [7:0]  op_timer;
    logic [7:0]  pend_byte;     // second response byte (low half of read data)
    logic        pend_valid;

    logic        byte_expired;
    logic        op_expired;
    logic        frame_done;
    logic        start_op;

    // Timeout flags and frame-completion / launch decisions for the current cycle.
    // A timeout is judged from the counter alone, so it wins over a byte arriving
    // in the same cycle. When qpi_on is already high the operation starts on the
    // same edge that takes the last frame byte, skipping the WAIT_RDY hold.
    always_comb begin
        byte_expired = (byte_timer == BYTE_TIMEOUT);
        op_expired   = (op_timer == OP_TIMEOUT);
        frame_done   = rx_valid && !byte_expired &&
                       (((state == S_ADDR) && (byte_cnt == 2'd2) && !is_write) ||
                        ((state == S_DATA) && (byte_cnt == 2'd1)));
        start_op     = qpi_on && (frame_done || (state == S_WAIT_RDY));
    end

    // Frame parser, psram handshake and response sequencer.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            is_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            byte_timer <= 16'd0;
            op_timer   <= 8'd0;
            pend_byte  <= 8'd0;
            pend_valid <= 1'b0;
            address    <= 23'd0;
            data_in    <= 16'd0;
            read_write <= 2'd0;
            quad_start <= 1'b0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            quad_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                            is_write   <= (rx_data == OP_WRITE);
                            byte_cnt   <= 2'd0;
                            byte_timer <= 16'd0;
                            state      <= S_ADDR;
                        end else begin
                            tx_data    <= RSP_BAD;
                            tx_valid   <= 1'b1;
                            pend_valid <= 1'b0;
                            state      <= S_RESP;
                        end
                    end
                end

                S_ADDR, S_DATA: begin
                    if (byte_expired) begin
                        // Partial frame abandoned silently.
                        byte_timer <= 16'd0;
                        byte_cnt   <= 2'd0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (rx_valid) begin
                        byte_timer <= 16'd0;
                        // Shifting 24 bits into 23 drops A2[7] on its own.
                        if (state == S_ADDR) begin
                            address <= {address[14:0], rx_data};
                        end else begin
                            data_in <= {data_in[7:0], rx_data};
                        end
                        if (start_op) begin
                            byte_cnt   <= 2'd0;
                            quad_start <= 1'b1;
                            read_write <= is_write ? 2'd1 : 2'd2;
                            op_timer   <= 8'd0;
                            state      <= S_ISSUE;
                        end else if (frame_done) begin
                            byte_cnt <= 2'd0;
                            state    <= S_WAIT_RDY;
                        end else if ((state == S_ADDR) && (byte_cnt == 2'd2)) begin
                            byte_cnt <= 2'd0;
                            state    <= S_DATA;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (byte_timer != 16'hFFFF) begin
                        byte_timer <= byte_timer + 16'd1;
                    end
                end

                S_WAIT_RDY: begin
                    if (start_op) begin
                        quad_start <= 1'b1;
                        read_write <= is_write ? 2'd1 : 2'd2;
                        op_timer   <= 8'd0;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    op_timer <= op_timer + 8'd1;
                    state    <= S_WAIT_END;
                end

                S_WAIT_END: begin
                    if (endcommand) begin
                        read_write <= 2'd0;
                        op_timer   <= 8'd0;
                        tx_valid   <= 1'b1;
                        state      <= S_RESP;
                        if (is_write) begin
                            tx_data    <= RSP_OK;
                            pend_valid <= 1'b0;
                        end else begin
                            tx_data    <= data_out[15:8];
                            pend_byte  <= data_out[7:0];
                            pend_valid <= 1'b1;
                        end
                    end else if (op_expired) begin
                        read_write <= 2'd0;
                        op_timer   <= 8'd0;
                        tx_data    <= RSP_TMO;
                        tx_valid   <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= S_RESP;
                    end else if (op_timer != 8'hFF) begin
                        op_timer <= op_timer + 8'd1;
                    end
                end

                S_RESP: begin
                    if (tx_ready) begin
                        if (pend_valid) begin
                            tx_data    <= pend_byte;
                            pend_valid <= 1'b0;
                        end else begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    tx_valid   <= 1'b0;
                    read_write <= 2'd0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_uart_cmd.sv
// Bench for psram_uart_cmd: directed scenarios followed by random frames, all
// checked every cycle against a frame-level model (byte queue in, reply queue out).
module tb_psram_uart_cmd;

    localparam logic [15:0] BYTE_TIMEOUT = 16'd8400;
    localparam logic [7:0]  OP_TIMEOUT   = 8'd64;

    localparam int M_IDLE   = 0;   // nothing in progress
    localparam int M_RECV   = 1;   // collecting frame bytes
    localparam int M_READY  = 2;   // frame complete, psram not ready
    localparam int M_FLIGHT = 3;   // operation launched
    localparam int M_REPLY  = 4;   // reply bytes pending

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        qpi_on = 1'b0;
    logic        endcommand = 1'b0;
    logic [15:0] data_out = 16'd0;
    logic [22:0] address;
    logic [1:0]  read_write;
    logic        quad_start;
    logic [15:0] data_in;
    logic        busy;

    psram_uart_cmd #(
        .BYTE_TIMEOUT(BYTE_TIMEOUT),
        .OP_TIMEOUT  (OP_TIMEOUT)
    ) dut (
        .mem_clk   (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .qpi_on    (qpi_on),
        .endcommand(endcommand),
        .data_out  (data_out),
        .address   (address),
        .read_write(read_write),
        .quad_start(quad_start),
        .data_in   (data_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = M_IDLE;
    logic [7:0]  m_frame[$];
    logic [7:0]  m_resp[$];
    int          m_gap = 0;
    int          m_age = 0;
    logic        exp_qs = 1'b0;
    logic [1:0]  exp_rw = 2'd0;
    logic [22:0] exp_addr = 23'd0;
    logic [15:0] exp_din = 16'd0;

    function automatic void model_reset();
        m_phase = M_IDLE;
        m_frame.delete();
        m_resp.delete();
        m_gap   = 0;
        m_age   = 0;
        exp_qs  = 1'b0;
        exp_rw  = 2'd0;
    endfunction

    function automatic void launch();
        exp_qs   = 1'b1;
        exp_rw   = (m_frame[0] == 8'h57) ? 2'd1 : 2'd2;
        exp_addr = {m_frame[1][6:0], m_frame[2], m_frame[3]};
        if (m_frame[0] == 8'h57) exp_din = {m_frame[4], m_frame[5]};
        m_age   = 0;
        m_phase = M_FLIGHT;
    endfunction

    function automatic void model_step();
        int need;
        exp_qs = 1'b0;
        case (m_phase)
            M_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        m_frame.delete();
                        m_frame.push_back(rx_data);
                        m_gap   = 0;
                        m_phase = M_RECV;
                    end else begin
                        m_resp.delete();
                        m_resp.push_back(8'h3F);
                        m_phase = M_REPLY;
                    end
                end
            end
            M_RECV: begin
                if (m_gap == int'(BYTE_TIMEOUT)) begin
                    m_frame.delete();
                    m_phase = M_IDLE;
                end else if (rx_valid) begin
                    m_frame.push_back(rx_data);
                    m_gap = 0;
                    need = (m_frame[0] == 8'h57) ? 6 : 4;
                    if (m_frame.size() == need) begin
                        m_phase = M_READY;
                        if (qpi_on) launch();
                    end
                end else begin
                    m_gap++;
                end
            end
            M_READY: begin
                if (qpi_on) launch();
            end
            M_FLIGHT: begin
                if (m_age == 0) begin
                    m_age = 1;          // start cycle: endcommand not looked at
                end else if (endcommand) begin
                    m_resp.delete();
                    if (m_frame[0] == 8'h57) begin
                        m_resp.push_back(8'h4B);
                    end else begin
                        m_resp.push_back(data_out[15:8]);
                        m_resp.push_back(data_out[7:0]);
                    end
                    exp_rw  = 2'd0;
                    m_phase = M_REPLY;
                end else if (m_age == int'(OP_TIMEOUT)) begin
                    m_resp.delete();
                    m_resp.push_back(8'h54);
                    exp_rw  = 2'd0;
                    m_phase = M_REPLY;
                end else begin
                    m_age++;
                end
            end
            M_REPLY: begin
                if (tx_ready) begin
                    void'(m_resp.pop_front());
                    if (m_resp.size() == 0) m_phase = M_IDLE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    logic [7:0] tx_log[$];
    int         qs_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, (m_phase != M_IDLE));
            check("quad_start", quad_start, exp_qs);
            check("read_write", read_write, exp_rw);
            check("tx_valid", tx_valid, (m_phase == M_REPLY));
            if (m_phase == M_REPLY) check("tx_data", tx_data, m_resp[0]);
            if (exp_rw != 2'd0) check("address", address, exp_addr);
            if (exp_rw == 2'd1) check("data_in", data_in, exp_din);
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (quad_start) qs_count++;
        end
    end

    // ---------------- psram responder and tx_ready driver ----------------
    int          end_delay = 5;      // 0 = never answer
    int          cd = 0;
    logic        use_rand = 1'b0;
    logic [15:0] rd_word = 16'hCAFE;
    int          ready_mode = 0;     // 0 always ready, 1 random, 2 stalled

    initial begin
        forever begin
            @(posedge clk);
            #1;
            endcommand = 1'b0;
            if (!rst_n) cd = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    endcommand = 1'b1;
                    data_out = use_rand ? 16'($urandom) : rd_word;
                end
            end
            if (quad_start && end_delay > 0) cd = end_delay;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(1, 0));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // gap_sel < 0 picks a random 0..3 cycle gap; the last byte never has a gap.
    task automatic send_frame(input logic wr, input logic [23:0] a, input logic [15:0] d, input int gap_sel);
        logic [7:0] bytes[6];
        int n;
        bytes[0] = wr ? 8'h57 : 8'h52;
        bytes[1] = a[23:16];
        bytes[2] = a[15:8];
        bytes[3] = a[7:0];
        bytes[4] = d[15:8];
        bytes[5] = d[7:0];
        n = wr ? 6 : 4;
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], (i == n - 1) ? 0 : ((gap_sel < 0) ? int'($urandom_range(3, 0)) : gap_sel));
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_phase == M_IDLE && busy == 1'b0) break;
            tick();
        end
        check(name, (i < budget), 1);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1);
        check({name, "_count"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            check(name, tx_log[i], (i == 0) ? b0 : b1);
        end
        tx_log.delete();
    endtask

    task automatic random_frame();
        int kind;
        int raise_at;
        int i;
        logic [7:0] b;
        kind       = int'($urandom_range(9, 0));
        qpi_on     = ($urandom_range(3, 0) != 0);
        end_delay  = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(40, 1));
        ready_mode = int'($urandom_range(1, 0));
        raise_at   = int'($urandom_range(15, 0));
        if (kind == 0) begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            send_byte(b, 0);
        end else begin
            send_frame(kind < 5, 24'($urandom), 16'($urandom), -1);
        end
        for (i = 0; i < 600; i++) begin
            if (m_phase == M_IDLE && busy == 1'b0) break;
            if (!qpi_on) begin
                if (raise_at == 0) qpi_on = 1'b1;
                else raise_at--;
            end
            if (m_phase == M_FLIGHT && $urandom_range(4, 0) == 0) begin
                // stray byte while an operation is in flight must be ignored
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("rand_idle", (i < 600), 1);
        tx_log.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int qs0;
        int i;

        repeat (3) tick();
        check("rst_address", address, 23'd0);
        check("rst_read_write", read_write, 2'd0);
        check("rst_quad_start", quad_start, 1'b0);
        check("rst_data_in", data_in, 16'd0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Write 57 01 23 45 BE EF
        qpi_on = 1'b1; ready_mode = 0; end_delay = 5; use_rand = 1'b0;
        tx_log.delete(); qs0 = qs_count;
        send_frame(1'b1, 24'h012345, 16'hBEEF, 0);
        check("wr_quad_start", quad_start, 1'b1);
        check("wr_address", address, 23'h012345);
        check("wr_data_in", data_in, 16'hBEEF);
        check("wr_read_write", read_write, 2'd1);
        check("model_addr", exp_addr, 23'h012345);
        check("model_din", exp_din, 16'hBEEF);
        tick();
        check("wr_qs_width", quad_start, 1'b0);
        check("wr_rw_hold", read_write, 2'd1);
        wait_idle(200, "wr_done");
        check_log("wr_resp", 1, 8'h4B, 8'h00);
        check("wr_rw_idle", read_write, 2'd0);
        check("wr_qs_count", qs_count - qs0, 1);

        // Read 52 00 00 10 returning CAFE
        rd_word = 16'hCAFE;
        send_frame(1'b0, 24'h000010, 16'h0000, 1);
        check("rd_read_write", read_write, 2'd2);
        check("rd_address", address, 23'h000010);
        wait_idle(200, "rd_done");
        check_log("rd_resp", 2, 8'hCA, 8'hFE);

        // Backpressure: tx_ready low for 20 cycles during the read reply
        ready_mode = 2;
        send_frame(1'b0, 24'h000010, 16'h0000, 0);
        for (i = 0; i < 100; i++) begin
            if (tx_valid) break;
            tick();
        end
        check("bp_reply_seen", tx_valid, 1'b1);
        repeat (20) begin
            tick();
            check("bp_hold_valid", tx_valid, 1'b1);
            check("bp_hold_data", tx_data, 8'hCA);
        end
        ready_mode = 0;
        wait_idle(50, "bp_done");
        check_log("bp_resp", 2, 8'hCA, 8'hFE);

        // Bad opcode
        send_byte(8'h41, 0);
        wait_idle(50, "bad_done");
        check_log("bad_op", 1, 8'h3F, 8'h00);

        // Byte timeout: 57 01 then silence
        qs0 = qs_count;
        send_byte(8'h57, 0);
        send_byte(8'h01, 0);
        check("bto_busy_during", busy, 1'b1);
        repeat (int'(BYTE_TIMEOUT) + 10) tick();
        check("bto_busy_after", busy, 1'b0);
        check("bto_no_start", qs_count - qs0, 0);
        check_log("bto_resp", 0, 8'h00, 8'h00);

        // psram not ready, then no endcommand -> 'T'
        qpi_on = 1'b0; end_delay = 0; qs0 = qs_count;
        send_frame(1'b0, 24'h7ABCDE, 16'h0000, 0);
        repeat (30) tick();
        check("nr_no_start", qs_count - qs0, 0);
        check("nr_busy", busy, 1'b1);
        qpi_on = 1'b1;
        tick();
        check("nr_start", quad_start, 1'b1);
        check("nr_read_write", read_write, 2'd2);
        wait_idle(300, "nr_done");
        check_log("op_timeout", 1, 8'h54, 8'h00);
        check("op_timeout_rw", read_write, 2'd0);

        // Asynchronous reset while waiting for endcommand
        end_delay = 0;
        send_frame(1'b1, 24'h00ABCD, 16'h5A5A, 0);
        repeat (5) tick();
        check("mid_rw_before", read_write, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rw", read_write, 2'd0);
        check("mid_rst_qs", quad_start, 1'b0);
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        end_delay = 3;
        tx_log.delete();
        send_frame(1'b1, 24'hFFFFFF, 16'h1234, 0);
        check("post_rst_qs", quad_start, 1'b1);
        check("post_rst_addr", address, 23'h7FFFFF);
        check("post_rst_din", data_in, 16'h1234);
        wait_idle(200, "post_rst_done");
        check_log("post_rst_resp", 1, 8'h4B, 8'h00);

        // Random frames against the model
        use_rand = 1'b1;
        for (int n = 0; n < 60; n++) random_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
